satisfaction_response_checker: RTL and testbench
================================================

# satisfaction_response_checker

Sequential response checker that sits at the receiving end of the satisfaction-detector stimulus interface. A stimulus source drives the five condition inputs, and the device under test returns `Has_Satisfaction`. This block accepts each applied vector through a valid/ready handshake, waits a programmable settle time, samples the response, and compares it against the reference rule. It reports pass/fail counts, the first failing vector, and whether all 32 input combinations have been seen.

## Interface
- `NUM_VECTORS`, default 32: number of vector checks per run before `done`.
- `CNT_W`, default 6: width of the pass/fail counters; counters saturate at all-ones.
- `SETTLE`, default 1: idle cycles between vector acceptance and response sampling; range 0..15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a run.
- `vec_valid`  in  1: stimulus vector present on the condition inputs.
- `vec_ready`  out  1: checker can accept a vector.
- `Has_Money`, `Has_Power`, `Has_Fame`, `Going_To_Die`, `Keeps_on_Trying`  in  1 each: applied vector.
  - Vector index `v` = {Has_Money, Has_Power, Has_Fame, Going_To_Die, Keeps_on_Trying}, with `Has_Money` as the MSB.
- `Has_Satisfaction`  in  1: response from the device under test.
- `busy`  out  1: a run is in progress.
- `done`  out  1: run complete; held until the next `start` or reset.
- `mismatch`  out  1: one-cycle pulse after a failing check.
- `pass_count`, `fail_count`  out  CNT_W each: check tallies.
- `first_fail_valid`  out  1: `first_fail_vec` holds a valid capture.
- `first_fail_vec`  out  5: index of the first failing vector.
- `coverage_full`  out  1: all 32 vector indices have been checked this run.

## Operation
- Reference rule, evaluated on the captured vector:
  - `exp = Keeps_on_Trying ? 1 : Going_To_Die ? 0 : (Has_Money | Has_Power | Has_Fame)`.
- States: IDLE, WAIT, SETTLE, CHECK, DONE.
- IDLE → WAIT on `start`.
  - Clears both counters, `first_fail_valid`, `first_fail_vec`, the checked-count, and the 32-bit seen mask.
- WAIT: `vec_ready = 1`.
  - On `vec_valid & vec_ready`, captures `v` into an internal register.
  - Goes to SETTLE with the settle counter set to `SETTLE`, or directly to CHECK when `SETTLE = 0`.
- SETTLE: decrements the counter each cycle; goes to CHECK when the counter reaches 1.
- CHECK, lasting one cycle, samples `Has_Satisfaction` at the closing edge:
  - Equal to `exp`: increment `pass_count`.
  - Otherwise: increment `fail_count` and pulse `mismatch` for the next cycle.
  - On the first failure of a run, also capture `first_fail_vec` and set `first_fail_valid`.
  - Set `seen[v]`, then increment the checked-count.
  - Go to DONE if the checked-count now equals `NUM_VECTORS`, else back to WAIT.
- DONE: `done = 1`, `busy = 0`, all results held; `start` → WAIT with a fresh clear.
- `start` in WAIT, SETTLE or CHECK aborts the current check (its result is not counted), clears all results, and goes to WAIT.
- `coverage_full = &seen`.
- Repeated vectors are counted again but do not change coverage.
- Counters saturate and never wrap.
- `vec_valid` outside WAIT is ignored.
  - The stimulus must hold the vector stable from acceptance through the CHECK cycle; the checker samples the response, not the inputs, after capture.

## Timing
- Reset values:
  - State IDLE.
  - `vec_ready = 0`, `busy = 0`, `done = 0`, `mismatch = 0`.
  - Counters 0, `first_fail_valid = 0`, `first_fail_vec = 0`, `coverage_full = 0`.
- Reset asserted mid-run clears everything immediately (asynchronous); the next run needs `start`.
- `busy = 1` in WAIT, SETTLE and CHECK.
- `vec_ready` is high in WAIT only; it goes low the cycle after acceptance.
- With acceptance at edge k, `Has_Satisfaction` is sampled at edge k+1+SETTLE.
  - Counters, `seen`, `first_fail_*` and `mismatch` are visible after that edge.
  - `vec_ready` returns high the same cycle.
- Throughput: one vector per 2+SETTLE cycles when `vec_valid` is held high.
- `done` rises the cycle after the final CHECK edge.
- `start` and a handshake in the same WAIT cycle: `start` wins and the vector is not accepted.

## Test plan
- Reset, then idle 5 cycles -> all outputs at reset values; `vec_ready = 0`.
- `start`, then vectors 0..31 from a correct detector, SETTLE = 1, `vec_valid` held high -> each acceptance 3 cycles apart.
  - Final: `pass_count = 32`, `fail_count = 0`, `coverage_full = 1`, `done = 1`, `first_fail_valid = 0`.
- Same run with the response stuck at 1:
  - Final: `fail_count = 9`, `pass_count = 23`, `first_fail_vec = 5'b00000`, `mismatch` pulsed 9 times.
- Same run with the response inverted only for `v = 5'b10010`:
  - Final: `fail_count = 1`, `first_fail_vec = 5'b10010`, `pass_count = 31`.
- Vector 7 applied 32 times -> `pass_count = 32`, `coverage_full = 0`, `done = 1`.
- Scenario 2 with `start` pulsed during the 10th SETTLE -> counters read 0 next cycle.
  - The run restarts; the final counts match scenario 2.
- Scenario 2 with `rst_n` low for one cycle at vector 20 -> outputs return to reset values asynchronously and stay IDLE until `start`.

Source files
------------

// File: rtl/satisfaction_response_checker_if.sv
// Stimulus-side bundle between a satisfaction-detector stimulus source and
// the response checker: the applied condition vector, its valid/ready
// handshake, and the detector's response.
interface satisfaction_response_checker_if;
    logic vec_valid;
    logic vec_ready;
    logic Has_Money;
    logic Has_Power;
    logic Has_Fame;
    logic Going_To_Die;
    logic Keeps_on_Trying;
    logic Has_Satisfaction;

    // Stimulus source / detector side
    modport master (
        output vec_valid,
        output Has_Money,
        output Has_Power,
        output Has_Fame,
        output Going_To_Die,
        output Keeps_on_Trying,
        output Has_Satisfaction,
        input  vec_ready
    );

    // Checker side
    modport slave (
        input  vec_valid,
        input  Has_Money,
        input  Has_Power,
        input  Has_Fame,
        input  Going_To_Die,
        input  Keeps_on_Trying,
        input  Has_Satisfaction,
        output vec_ready
    );
endinterface

// File: rtl/satisfaction_response_checker.sv
// Response checker for the satisfaction detector: accepts one condition
// vector per handshake, waits SETTLE cycles, samples Has_Satisfaction and
// compares it with the reference rule. Keeps saturating pass/fail tallies,
// the first failing vector, and a 32-entry coverage mask.
module satisfaction_response_checker #(
    parameter int unsigned NUM_VECTORS = 32,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned SETTLE      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    satisfaction_response_checker_if.slave        stim,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  mismatch,
    output logic [CNT_W-1:0]                      pass_count,
    output logic [CNT_W-1:0]                      fail_count,
    output logic                                  first_fail_valid,
    output logic [4:0]                            first_fail_vec,
    output logic                                  coverage_full
);

    localparam int unsigned CHK_W = $clog2(NUM_VECTORS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         settle_q, settle_d;
    logic [4:0]         vec_q, vec_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               ffv_q, ffv_d;
    logic [4:0]         ffvec_q, ffvec_d;
    logic [CHK_W-1:0]   chk_q, chk_d;
    logic [31:0]        seen_q, seen_d;
    logic               mismatch_q, mismatch_d;

    logic [4:0]         stim_vec;
    logic               exp_resp;
    logic [CHK_W-1:0]   chk_inc;

    // Index ordering: Has_Money is the MSB, Keeps_on_Trying the LSB
    assign stim_vec = {stim.Has_Money, stim.Has_Power, stim.Has_Fame,
                       stim.Going_To_Die, stim.Keeps_on_Trying};

    // Reference rule on the captured vector
    assign exp_resp = vec_q[0] ? 1'b1 :
                      vec_q[1] ? 1'b0 :
                      (vec_q[4] | vec_q[3] | vec_q[2]);

    assign chk_inc = chk_q + CHK_W'(1);

    // Next-state, capture and tally logic; start overrides everything
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        vec_d      = vec_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        chk_d      = chk_q;
        seen_d     = seen_q;
        mismatch_d = 1'b0;

        if (start) begin
            state_d  = S_WAIT;
            settle_d = '0;
            pass_d   = '0;
            fail_d   = '0;
            ffv_d    = 1'b0;
            ffvec_d  = '0;
            chk_d    = '0;
            seen_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (stim.vec_valid) begin
                        vec_d = stim_vec;
                        if (SETTLE == 0) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d  = S_SETTLE;
                            settle_d = 4'(SETTLE);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_q <= 4'd1) begin
                        state_d = S_CHECK;
                    end
                    if (settle_q != '0) begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (stim.Has_Satisfaction == exp_resp) begin
                        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                        mismatch_d = 1'b1;
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    seen_d[vec_q] = 1'b1;
                    chk_d         = chk_inc;
                    if (chk_inc == CHK_W'(NUM_VECTORS)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_IDLE, S_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and result registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            vec_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            chk_q      <= '0;
            seen_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            vec_q      <= vec_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ffv_q      <= ffv_d;
            ffvec_q    <= ffvec_d;
            chk_q      <= chk_d;
            seen_q     <= seen_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign stim.vec_ready   = (state_q == S_WAIT);
    assign busy             = (state_q == S_WAIT) || (state_q == S_SETTLE) ||
                              (state_q == S_CHECK);
    assign done             = (state_q == S_DONE);
    assign mismatch         = mismatch_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign coverage_full    = &seen_q;

endmodule

// File: tb/tb_satisfaction_response_checker.sv
// Directed bench for satisfaction_response_checker: drives condition vectors
// through the handshake from a small detector model (correct, stuck-at-1, or
// wrong on one vector) and checks tallies, coverage and control outputs
// against hand-computed values.
module tb_satisfaction_response_checker;

    localparam int SETTLE_P = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [5:0]  pass_count;
    logic [5:0]  fail_count;
    logic        first_fail_valid;
    logic [4:0]  first_fail_vec;
    logic        coverage_full;

    int tests_run;
    int tests_failed;
    int mode;
    int cyc;
    int mism_cnt;
    int bad_gap;

    satisfaction_response_checker_if stim_if ();

    satisfaction_response_checker #(
        .NUM_VECTORS (32),
        .CNT_W       (6),
        .SETTLE      (SETTLE_P)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stim             (stim_if),
        .busy             (busy),
        .done             (done),
        .mismatch         (mismatch),
        .pass_count       (pass_count),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .coverage_full    (coverage_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial mism_cnt = 0;
    always @(negedge clk) if (mismatch === 1'b1) mism_cnt = mism_cnt + 1;

    // Detector under test: mode 0 correct, 1 stuck at 1, 2 wrong only on 5'b10010
    function automatic logic detector(input logic [4:0] v, input int m);
        logic ok;
        if (v[0])      ok = 1'b1;
        else if (v[1]) ok = 1'b0;
        else           ok = v[4] | v[3] | v[2];
        case (m)
            1:       return 1'b1;
            2:       return (v == 5'b10010) ? ~ok : ok;
            default: return ok;
        endcase
    endfunction

    always_comb stim_if.Has_Satisfaction = detector({stim_if.Has_Money, stim_if.Has_Power,
        stim_if.Has_Fame, stim_if.Going_To_Die, stim_if.Keeps_on_Trying}, mode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests_run = tests_run + 1;
        if (got !== expv) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic set_vec(input logic [4:0] v);
        stim_if.Has_Money       = v[4];
        stim_if.Has_Power       = v[3];
        stim_if.Has_Fame        = v[2];
        stim_if.Going_To_Die    = v[1];
        stim_if.Keeps_on_Trying = v[0];
    endtask

    // Called #1 after an edge; leaves start low and the checker in WAIT
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Feeds n vectors (i, or `fixed` when >= 0); returns #1 after the last acceptance edge
    task automatic run_vectors(input int n, input int fixed);
        int waited;
        int last_acc;
        bad_gap  = 0;
        last_acc = 0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (stim_if.vec_ready !== 1'b1 && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (waited >= 20) begin
                check("ready_timeout", 32'(waited), 32'd0);
                return;
            end
            set_vec((fixed >= 0) ? 5'(fixed) : 5'(i));
            stim_if.vec_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i > 0 && (cyc - last_acc) != 2 + SETTLE_P) bad_gap++;
            last_acc = cyc;
        end
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("done_rise", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_vec_ready"}, 32'(stim_if.vec_ready), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_mismatch"},  32'(mismatch), 32'd0);
        check({tag, "_pass"},      32'(pass_count), 32'd0);
        check({tag, "_fail"},      32'(fail_count), 32'd0);
        check({tag, "_ffv"},       32'(first_fail_valid), 32'd0);
        check({tag, "_ffvec"},     32'(first_fail_vec), 32'd0);
        check({tag, "_cov"},       32'(coverage_full), 32'd0);
    endtask

    initial begin
        int m0;
        tests_run         = 0;
        tests_failed      = 0;
        cyc               = 0;
        mode              = 0;
        rst_n             = 1'b0;
        start             = 1'b0;
        stim_if.vec_valid = 1'b0;
        set_vec(5'd0);

        // Reset, then idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_cleared("reset");

        // Correct detector, all 32 vectors
        mode = 0;
        m0   = mism_cnt;
        pulse_start();
        check("run_busy", 32'(busy), 32'd1);
        run_vectors(32, -1);
        check("ok_gap", 32'(bad_gap), 32'd0);
        wait_done();
        check("ok_pass", 32'(pass_count), 32'd32);
        check("ok_fail", 32'(fail_count), 32'd0);
        check("ok_cov",  32'(coverage_full), 32'd1);
        check("ok_done", 32'(done), 32'd1);
        check("ok_busy", 32'(busy), 32'd0);
        check("ok_ffv",  32'(first_fail_valid), 32'd0);
        check("ok_mism", 32'(mism_cnt - m0), 32'd0);

        // Response stuck at 1
        mode = 1;
        m0   = mism_cnt;
        pulse_start();
        run_vectors(32, -1);
        wait_done();
        check("stuck_fail",  32'(fail_count), 32'd9);
        check("stuck_pass",  32'(pass_count), 32'd23);
        check("stuck_ffv",   32'(first_fail_valid), 32'd1);
        check("stuck_ffvec", 32'(first_fail_vec), 32'd0);
        check("stuck_mism",  32'(mism_cnt - m0), 32'd9);

        // Response wrong only for 5'b10010
        mode = 2;
        m0   = mism_cnt;
        pulse_start();
        run_vectors(32, -1);
        wait_done();
        check("one_fail",  32'(fail_count), 32'd1);
        check("one_pass",  32'(pass_count), 32'd31);
        check("one_ffvec", 32'(first_fail_vec), 32'd18);
        check("one_mism",  32'(mism_cnt - m0), 32'd1);

        // Vector 7 repeated: counts accumulate, coverage does not fill
        mode = 0;
        pulse_start();
        run_vectors(32, 7);
        wait_done();
        check("rep_pass", 32'(pass_count), 32'd32);
        check("rep_cov",  32'(coverage_full), 32'd0);
        check("rep_done", 32'(done), 32'd1);

        // Start during the 10th SETTLE aborts and restarts the run
        pulse_start();
        run_vectors(10, -1);
        check("abort_pre_pass", 32'(pass_count), 32'd9);
        stim_if.vec_valid = 1'b0;
        pulse_start();
        check("abort_pass",  32'(pass_count), 32'd0);
        check("abort_fail",  32'(fail_count), 32'd0);
        check("abort_ready", 32'(stim_if.vec_ready), 32'd1);
        run_vectors(32, -1);
        wait_done();
        check("abort_final_pass", 32'(pass_count), 32'd32);
        check("abort_final_fail", 32'(fail_count), 32'd0);
        check("abort_final_cov",  32'(coverage_full), 32'd1);

        // Asynchronous reset mid-run at vector 20
        pulse_start();
        run_vectors(20, -1);
        check("arst_pre_pass", 32'(pass_count), 32'd19);
        #2 rst_n = 1'b0;
        #1;
        check_cleared("arst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_idle_ready", 32'(stim_if.vec_ready), 32'd0);
        check("arst_idle_busy",  32'(busy), 32'd0);
        check("arst_idle_pass",  32'(pass_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
